// File: rtl/rv32i_types_pkg.sv
// Shared types for the vector address path: element width, address generator
// states and the default maximum vector length.
package rv32i_types_pkg;

  localparam int VL_MAX = 32;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } vaddr_state_t;

  // Byte size of one element; also the unit-stride step.
  function automatic logic [31:0] sew_bytes(input sew_t s);
    case (s)
      SEW_16:  sew_bytes = 32'd2;
      SEW_32:  sew_bytes = 32'd4;
      default: sew_bytes = 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/vaddr_accum.sv
// Per-lane byte-address accumulator: loads a start address, then adds a fixed
// step each time the element pair advances. Wraps modulo 2^32.
module vaddr_accum (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_en,
  input  logic [31:0] load_val,
  input  logic        step_en,
  input  logic [31:0] step,
  output logic [31:0] addr
);

  logic [31:0] addr_q, addr_d;

  // Load has priority; a step only happens while the walk is in progress.
  always_comb begin
    addr_d = addr_q;
    if (load_en)      addr_d = load_val;
    else if (step_en) addr_d = addr_q + step;
  end

  // Address register.
  always_ff @(posedge CLK) begin
    if (RST) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/vector_addr_gen.sv
// Vector element address generator: walks elements two at a time, holding each
// pair on the scheduler lanes until every active lane has reported arrival.
module vector_addr_gen
  import rv32i_types_pkg::*;
#(
  parameter int MAX_VL = VL_MAX,
  localparam int VLW = $clog2(MAX_VL) + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            load_in,
  input  logic            store_in,
  input  logic [31:0]     base,
  input  logic [31:0]     stride,
  input  logic            strided,
  input  logic [VLW-1:0]  vl,
  input  sew_t            sew_in,
  input  logic [31:0]     vs_rdata0,
  input  logic [31:0]     vs_rdata1,
  input  logic            arrived0,
  input  logic            arrived1,
  input  logic            sched_exception,
  output logic [31:0]     addr0,
  output logic [31:0]     addr1,
  output logic [31:0]     storedata0,
  output logic [31:0]     storedata1,
  output logic            load,
  output logic            store,
  output logic            lane1_valid,
  output sew_t            sew,
  output logic [VLW-1:0]  rd_idx0,
  output logic [VLW-1:0]  rd_idx1,
  output logic            busy,
  output logic            done,
  output logic            exception,
  output logic [VLW-1:0]  fault_idx
);

  localparam logic [VLW:0] ONE_X = (VLW+1)'(1);
  localparam logic [VLW:0] TWO_X = (VLW+1)'(2);

  vaddr_state_t   state_q, state_d;
  logic [VLW-1:0] idx_q, idx_d;
  logic [VLW-1:0] vl_q, vl_d;
  logic [VLW-1:0] fault_idx_q, fault_idx_d;
  logic [31:0]    stride_q, stride_d;
  logic           load_q, load_d, store_q, store_d;
  sew_t           sew_q, sew_d;
  logic           seen0_q, seen0_d, seen1_q, seen1_d;
  logic           zdone_q, zdone_d;

  logic           run, lane1_c, pair_done, acc_load, acc_step;
  logic [VLW:0]   idx_x, vl_x;
  logic [31:0]    stride_eff_in, step2, base1;

  assign run           = (state_q == RUN);
  assign idx_x         = {1'b0, idx_q};
  assign vl_x          = {1'b0, vl_q};
  assign lane1_c       = run && ((idx_x + ONE_X) < vl_x);
  assign stride_eff_in = strided ? stride : sew_bytes(sew_in);
  assign base1         = base + stride_eff_in;
  assign step2         = stride_q + stride_q;
  // A fault on the pair wins over any same-cycle arrival.
  assign pair_done     = run && !sched_exception && (seen0_q || arrived0) &&
                         (!lane1_c || seen1_q || arrived1);

  // Next-state, operand latching, pair advance and sticky arrival flags.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vl_d        = vl_q;
    fault_idx_d = fault_idx_q;
    stride_d    = stride_q;
    load_d      = load_q;
    store_d     = store_q;
    sew_d       = sew_q;
    seen0_d     = seen0_q;
    seen1_d     = seen1_q;
    zdone_d     = 1'b0;
    acc_load    = 1'b0;
    acc_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          fault_idx_d = '0;
          sew_d       = sew_in;
          if (vl != '0) begin
            state_d  = RUN;
            idx_d    = '0;
            vl_d     = vl;
            stride_d = stride_eff_in;
            load_d   = load_in;
            store_d  = store_in;
            seen0_d  = 1'b0;
            seen1_d  = 1'b0;
            acc_load = 1'b1;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (sched_exception) begin
          state_d     = ABORT;
          fault_idx_d = idx_q;
          seen0_d     = 1'b0;
          seen1_d     = 1'b0;
        end else if (pair_done) begin
          seen0_d  = 1'b0;
          seen1_d  = 1'b0;
          idx_d    = idx_q + VLW'(2);
          acc_step = 1'b1;
          if ((idx_x + TWO_X) >= vl_x) state_d = DONE;
        end else begin
          seen0_d = seen0_q | arrived0;
          seen1_d = seen1_q | (arrived1 & lane1_c);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset drops everything without emitting a pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vl_q        <= '0;
      fault_idx_q <= '0;
      stride_q    <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      sew_q       <= SEW_8;
      seen0_q     <= 1'b0;
      seen1_q     <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vl_q        <= vl_d;
      fault_idx_q <= fault_idx_d;
      stride_q    <= stride_d;
      load_q      <= load_d;
      store_q     <= store_d;
      sew_q       <= sew_d;
      seen0_q     <= seen0_d;
      seen1_q     <= seen1_d;
      zdone_q     <= zdone_d;
    end
  end

  // Lane 0 starts at base, lane 1 one element later; both step by two elements.
  vaddr_accum u_acc0 (
    .CLK(CLK), .RST(RST), .load_en(acc_load), .load_val(base),
    .step_en(acc_step), .step(step2), .addr(addr0)
  );

  vaddr_accum u_acc1 (
    .CLK(CLK), .RST(RST), .load_en(acc_load), .load_val(base1),
    .step_en(acc_step), .step(step2), .addr(addr1)
  );

  assign load        = run & load_q;
  assign store       = run & store_q;
  assign storedata0  = store ? vs_rdata0 : '0;
  assign storedata1  = store ? vs_rdata1 : '0;
  assign lane1_valid = lane1_c;
  assign rd_idx0     = run ? idx_q : '0;
  assign rd_idx1     = run ? (idx_q + VLW'(1)) : '0;
  assign sew         = sew_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE) | zdone_q;
  assign exception   = (state_q == ABORT);
  assign fault_idx   = fault_idx_q;

endmodule

// File: tb/tb_vector_addr_gen.sv
// Bench for vector_addr_gen: directed table, hand-written corner sequences and
// randomized operations checked against an element-address model.
module tb_vector_addr_gen;
  import rv32i_types_pkg::*;

  localparam int VLW = $clog2(VL_MAX) + 1;

  logic CLK = 1'b0, RST = 1'b1;
  logic start = 0, load_in = 0, store_in = 0, strided = 0;
  logic [31:0] base = 0, stride = 0, vs_rdata0 = 0, vs_rdata1 = 0;
  logic [VLW-1:0] vl = 0;
  sew_t sew_in = SEW_8;
  logic arrived0 = 0, arrived1 = 0, sched_exception = 0;
  logic [31:0] addr0, addr1, storedata0, storedata1;
  logic load, store, lane1_valid, busy, done, exception;
  sew_t sew;
  logic [VLW-1:0] rd_idx0, rd_idx1, fault_idx;

  int pass_cnt = 0, tot_cnt = 0;

  vector_addr_gen dut (
    .CLK(CLK), .RST(RST), .start(start), .load_in(load_in), .store_in(store_in),
    .base(base), .stride(stride), .strided(strided), .vl(vl), .sew_in(sew_in),
    .vs_rdata0(vs_rdata0), .vs_rdata1(vs_rdata1), .arrived0(arrived0),
    .arrived1(arrived1), .sched_exception(sched_exception), .addr0(addr0),
    .addr1(addr1), .storedata0(storedata0), .storedata1(storedata1),
    .load(load), .store(store), .lane1_valid(lane1_valid), .sew(sew),
    .rd_idx0(rd_idx0), .rd_idx1(rd_idx1), .busy(busy), .done(done),
    .exception(exception), .fault_idx(fault_idx)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ebytes(input sew_t s);
    case (s)
      SEW_16:  return 32'd2;
      SEW_32:  return 32'd4;
      default: return 32'd1;
    endcase
  endfunction

  // One whole operation. Element i lives at b + i*stride_eff; the bench decides
  // when each lane arrives (fd0/fd1 cycles into the pair, or random if < 0),
  // so it knows exactly which pair must be on the lanes in every cycle.
  task automatic run_op(input logic [31:0] b, input logic [31:0] s, input logic strd,
                        input int n, input sew_t sw, input logic st,
                        input int fd0, input int fd1,
                        output logic [31:0] fa0, output logic [31:0] fa1,
                        output logic [31:0] la0, output logic [31:0] la1);
    logic [31:0] se;
    se = strd ? s : ebytes(sw);
    fa0 = 0; fa1 = 0; la0 = 0; la1 = 0;
    @(negedge CLK);
    start = 1; base = b; stride = s; strided = strd; vl = n[VLW-1:0];
    sew_in = sw; load_in = !st; store_in = st;
    @(negedge CLK);
    start = 0; base = $urandom; stride = $urandom; strided = 1'($urandom);
    vl = VLW'($urandom); sew_in = sew_t'($urandom_range(0, 2));
    load_in = 1'($urandom); store_in = 1'($urandom);
    if (n == 0) begin
      chk("vl0_done", done, 1); chk("vl0_busy", busy, 0);
      chk("vl0_load", load, 0); chk("vl0_store", store, 0);
      @(negedge CLK);
      chk("vl0_done_clr", done, 0); chk("vl0_load2", load | store, 0);
      return;
    end
    for (int p = 0; p < n; p += 2) begin
      int d0, d1, last;
      logic l1v;
      d0 = (fd0 >= 0) ? fd0 : $urandom_range(0, 3);
      d1 = (fd1 >= 0) ? fd1 : $urandom_range(0, 3);
      l1v = (p + 1 < n);
      last = (l1v && d1 > d0) ? d1 : d0;
      for (int c = 0; c <= last; c++) begin
        chk("addr0", addr0, b + 32'(p) * se);
        chk("addr1", addr1, b + 32'(p + 1) * se);
        chk("rd_idx0", 32'(rd_idx0), 32'(p));
        chk("rd_idx1", 32'(rd_idx1), 32'(p + 1));
        chk("lane1_valid", lane1_valid, l1v);
        chk("load", load, !st);
        chk("store", store, st);
        chk("busy", busy, 1);
        chk("done_run", done, 0);
        chk("sew", 32'(sew), 32'(sw));
        if (p == 0 && c == 0) begin fa0 = addr0; fa1 = addr1; end
        la0 = addr0; la1 = addr1;
        vs_rdata0 = $urandom; vs_rdata1 = $urandom;
        #1;
        chk("storedata0", storedata0, st ? vs_rdata0 : 32'd0);
        chk("storedata1", storedata1, st ? vs_rdata1 : 32'd0);
        arrived0 = (c == d0);
        arrived1 = l1v ? (c == d1) : 1'($urandom);
        start = ($urandom_range(0, 3) == 0);
        base = $urandom;
        @(negedge CLK);
      end
    end
    arrived0 = 0; arrived1 = 0; start = 0;
    chk("done_pulse", done, 1); chk("done_busy", busy, 1);
    chk("done_ls", load | store, 0);
    @(negedge CLK);
    chk("done_clr", done, 0); chk("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic [31:0] b, s;
    logic strd;
    int n;
    sew_t sw;
    logic st;
    logic [31:0] fa0, fa1, la0, la1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] fa0, fa1, la0, la1;
    tbl[0] = '{32'h1000, 32'h0, 1'b0, 4, SEW_32, 1'b0, 32'h1000, 32'h1004, 32'h1008, 32'h100C};
    tbl[1] = '{32'h20, 32'h0, 1'b0, 3, SEW_8, 1'b0, 32'h20, 32'h21, 32'h22, 32'h23};
    tbl[2] = '{32'h100, 32'hFFFFFFF8, 1'b1, 2, SEW_32, 1'b1, 32'h100, 32'hF8, 32'h100, 32'hF8};
    tbl[3] = '{32'h10, 32'h0, 1'b0, 5, SEW_16, 1'b1, 32'h10, 32'h12, 32'h18, 32'h1A};
    tbl[4] = '{32'hFFFFFFFC, 32'h0, 1'b0, 4, SEW_32, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8};
    tbl[5] = '{32'h0, 32'h100, 1'b1, 6, SEW_8, 1'b1, 32'h0, 32'h100, 32'h400, 32'h500};

    // Reset state.
    @(negedge CLK);
    chk("rst_addr0", addr0, 0); chk("rst_addr1", addr1, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_exc", exception, 0); chk("rst_ls", load | store, 0);
    chk("rst_sew", 32'(sew), 0); chk("rst_fidx", 32'(fault_idx), 0);
    chk("rst_rdidx1", 32'(rd_idx1), 0);
    RST = 0;
    @(negedge CLK);

    // Directed table, both lanes arriving together.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].b, tbl[i].s, tbl[i].strd, tbl[i].n, tbl[i].sw, tbl[i].st,
             0, 0, fa0, fa1, la0, la1);
      chk("tbl_first0", fa0, tbl[i].fa0); chk("tbl_first1", fa1, tbl[i].fa1);
      chk("tbl_last0", la0, tbl[i].la0);  chk("tbl_last1", la1, tbl[i].la1);
    end

    // Skewed arrivals: lane 1 three cycles after lane 0.
    run_op(32'h3000, 32'h0, 1'b0, 4, SEW_32, 1'b0, 0, 3, fa0, fa1, la0, la1);
    chk("skew_last0", la0, 32'h3008);

    // Empty vector.
    run_op(32'h40, 32'h0, 1'b0, 0, SEW_32, 1'b0, 0, 0, fa0, fa1, la0, la1);

    // Fault on the second pair of a vl=6 op, with arrivals in the same cycle.
    @(negedge CLK);
    start = 1; base = 32'h40; strided = 0; vl = 6; sew_in = SEW_32;
    load_in = 1; store_in = 0;
    @(negedge CLK);
    start = 0;
    chk("flt_a0_p0", addr0, 32'h40);
    arrived0 = 1; arrived1 = 1;
    @(negedge CLK);
    chk("flt_a0_p1", addr0, 32'h48); chk("flt_idx_p1", 32'(rd_idx0), 2);
    sched_exception = 1;
    @(negedge CLK);
    sched_exception = 0; arrived0 = 0; arrived1 = 0;
    chk("flt_exc", exception, 1); chk("flt_fidx", 32'(fault_idx), 2);
    chk("flt_done", done, 0); chk("flt_busy", busy, 1); chk("flt_ls", load, 0);
    @(negedge CLK);
    chk("flt_exc_clr", exception, 0); chk("flt_busy_clr", busy, 0);
    chk("flt_done2", done, 0); chk("flt_fidx_hold", 32'(fault_idx), 2);
    chk("flt_a0_hold", addr0, 32'h50 - 32'h8);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    chk("rst_fidx_clr", 32'(fault_idx), 0);
    run_op(32'h700, 32'h0, 1'b0, 2, SEW_16, 1'b0, 1, 0, fa0, fa1, la0, la1);
    chk("after_flt_a1", fa1, 32'h702);

    // Reset in the middle of a walk.
    @(negedge CLK);
    start = 1; base = 32'h500; strided = 0; vl = 8; sew_in = SEW_32;
    load_in = 0; store_in = 1;
    @(negedge CLK);
    start = 0;
    chk("mid_a0", addr0, 32'h500);
    arrived0 = 1; arrived1 = 1;
    @(negedge CLK);
    arrived0 = 0; arrived1 = 0; RST = 1;
    @(negedge CLK);
    RST = 0;
    chk("mid_addr0", addr0, 0); chk("mid_addr1", addr1, 0);
    chk("mid_busy", busy, 0); chk("mid_ls", load | store, 0);
    chk("mid_done", done, 0); chk("mid_exc", exception, 0);
    chk("mid_l1v", lane1_valid, 0); chk("mid_rdidx1", 32'(rd_idx1), 0);
    @(negedge CLK);
    chk("mid_done2", done, 0);

    // Randomized operations.
    for (int k = 0; k < 30; k++) begin
      logic [31:0] rb, rs;
      rb = $urandom; rs = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
      run_op(rb, rs, 1'($urandom), $urandom_range(0, VL_MAX), sew_t'($urandom_range(0, 2)),
             1'($urandom), -1, -1, fa0, fa1, la0, la1);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
